// File: rtl/nfc_command_dispatcher.sv
// Command dispatcher between the AXI-Lite register block and the NAND controller core.
// Queues written commands, issues them one at a time and supervises each until done or timeout.
module nfc_command_dispatcher #(
  parameter int FIFO_AW        = 2,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iCommand,
  input  logic        iCommandValid,
  input  logic [31:0] iAddress,
  input  logic [15:0] iLength,
  output logic [7:0]  oCmdOpcode,
  output logic [7:0]  oCmdTarget,
  output logic [31:0] oCmdAddress,
  output logic [15:0] oCmdLength,
  output logic        oCmdValid,
  input  logic        iCmdReady,
  input  logic        iCmdDone,
  input  logic        iCmdError,
  output logic        oCommandFail,
  output logic [23:0] oNFCStatus
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;
  localparam int TW    = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_e;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [7:0]  target;
    logic [31:0] addr;
    logic [15:0] len;
  } cmd_t;

  cmd_t mem [DEPTH];
  cmd_t in_cmd;

  state_e             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cmd_t               cmd_q, cmd_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               fail_q, fail_d;
  logic               timeout_q, timeout_d;
  logic [7:0]         last_op_q, last_op_d;
  logic [23:0]        status_q, status_d;

  logic full, empty, push, pop, clear_req, set_fail, set_timeout;

  assign in_cmd = '{opcode: iCommand[7:0], target: iCommand[15:8], addr: iAddress, len: iLength};

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cmd_valid_d = cmd_valid_q;
    timer_d     = timer_q;
    last_op_d   = last_op_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    set_timeout = 1'b0;

    full      = (count_q == CW'(DEPTH));
    empty     = (count_q == '0);
    clear_req = iCommandValid & iCommand[31];
    // Full is judged on the registered count, so a same-cycle pop never rescues a write.
    push      = iCommandValid & ~iCommand[31] & (iCommand[7:0] != 8'h00) & ~full;
    set_fail  = iCommandValid & ~iCommand[31] & ((iCommand[7:0] == 8'h00) | full);
    pop       = (state_q == IDLE) & ~empty;

    case (state_q)
      IDLE: begin
        if (pop) begin
          cmd_d       = mem[rd_ptr_q];
          cmd_valid_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (iCmdReady) begin
          cmd_valid_d = 1'b0;
          timer_d     = '0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        timer_d = timer_q + TW'(1);
        if (iCmdDone) begin
          last_op_d = cmd_q.opcode;
          state_d   = IDLE;
          if (iCmdError) set_fail = 1'b1;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          last_op_d   = cmd_q.opcode;
          set_fail    = 1'b1;
          set_timeout = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A set in the same cycle as a clear wins.
    fail_d    = set_fail    ? 1'b1 : (clear_req ? 1'b0 : fail_q);
    timeout_d = set_timeout ? 1'b1 : (clear_req ? 1'b0 : timeout_q);

    status_d = {last_op_d, 6'b0, timeout_d, fail_d,
                (count_d == '0), (count_d == CW'(DEPTH)), state_d, 4'(count_d)};
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_cmd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      timer_q     <= '0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      last_op_q   <= 8'h00;
      status_q    <= 24'h000080;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      timer_q     <= timer_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
      last_op_q   <= last_op_d;
      status_q    <= status_d;
    end
  end

  assign oCmdOpcode   = cmd_q.opcode;
  assign oCmdTarget   = cmd_q.target;
  assign oCmdAddress  = cmd_q.addr;
  assign oCmdLength   = cmd_q.len;
  assign oCmdValid    = cmd_valid_q;
  assign oCommandFail = fail_q;
  assign oNFCStatus   = status_q;

endmodule

// File: tb/tb_nfc_command_dispatcher.sv
// Scoreboard bench for nfc_command_dispatcher: expected issues are queued at stimulus time,
// a negedge monitor pops and compares on every accepted command.
module tb_nfc_command_dispatcher;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] iCommand = '0;
  logic        iCommandValid = 1'b0;
  logic [31:0] iAddress = '0;
  logic [15:0] iLength = '0;
  logic [7:0]  oCmdOpcode, oCmdTarget;
  logic [31:0] oCmdAddress;
  logic [15:0] oCmdLength;
  logic        oCmdValid;
  logic        iCmdReady = 1'b0;
  logic        iCmdDone = 1'b0;
  logic        iCmdError = 1'b0;
  logic        oCommandFail;
  logic [23:0] oNFCStatus;

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  tgt;
    logic [31:0] addr;
    logic [15:0] len;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  nfc_command_dispatcher #(.FIFO_AW(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .iCommand(iCommand), .iCommandValid(iCommandValid),
    .iAddress(iAddress), .iLength(iLength),
    .oCmdOpcode(oCmdOpcode), .oCmdTarget(oCmdTarget),
    .oCmdAddress(oCmdAddress), .oCmdLength(oCmdLength),
    .oCmdValid(oCmdValid), .iCmdReady(iCmdReady),
    .iCmdDone(iCmdDone), .iCmdError(iCmdError),
    .oCommandFail(oCommandFail), .oNFCStatus(oNFCStatus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted command must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && oCmdValid && iCmdReady) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_issue: got op=%h addr=%h, nothing expected", oCmdOpcode, oCmdAddress);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (oCmdOpcode !== e.op || oCmdTarget !== e.tgt || oCmdAddress !== e.addr || oCmdLength !== e.len) begin
          fails++;
          $display("FAIL issue_fields: got %h/%h/%h/%h expected %h/%h/%h/%h",
                   oCmdOpcode, oCmdTarget, oCmdAddress, oCmdLength, e.op, e.tgt, e.addr, e.len);
        end
      end
    end
  end

  task automatic write_cmd(input logic [31:0] c, input logic [31:0] a, input logic [15:0] l,
                           input bit expect_issue);
    exp_t e;
    if (expect_issue) begin
      e.op = c[7:0]; e.tgt = c[15:8]; e.addr = a; e.len = l;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    iCommand = c; iAddress = a; iLength = l; iCommandValid = 1'b1;
    @(posedge clk); #1;
    iCommandValid = 1'b0; iCommand = '0;
  endtask

  task automatic pulse_done(input logic err);
    @(posedge clk); #1;
    iCmdDone = 1'b1; iCmdError = err;
    @(posedge clk); #1;
    iCmdDone = 1'b0; iCmdError = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_status", 32'(oNFCStatus), 32'h000080);
    check("reset_valid", 32'(oCmdValid), 0);
    check("reset_fail", 32'(oCommandFail), 0);
    rst = 1'b0;

    // 1: single command, two-cycle latency, done after a while
    iCmdReady = 1'b1;
    write_cmd(32'h0000_0380, 32'h0001_2000, 16'd4096, 1'b1);
    @(negedge clk);
    check("t1_valid_cycle1", 32'(oCmdValid), 0);
    @(negedge clk);
    check("t1_valid_cycle2", 32'(oCmdValid), 1);
    repeat (8) @(posedge clk);
    pulse_done(1'b0);
    @(negedge clk);
    check("t1_last_op", 32'(oNFCStatus[23:16]), 32'h80);
    check("t1_state", 32'(oNFCStatus[5:4]), 0);
    check("t1_fail", 32'(oCommandFail), 0);
    check("t1_empty", 32'(oNFCStatus[7]), 1);

    // 2: fill FIFO with core stalled, overflow drops and fails
    iCmdReady = 1'b0;
    for (int i = 0; i < 5; i++)
      write_cmd(32'h0000_0010 + 32'(i) + (32'(i) << 8), 32'h1000 * (i + 1), 16'(512 + i), 1'b1);
    @(negedge clk);
    check("t2_count", 32'(oNFCStatus[3:0]), 4);
    check("t2_full", 32'(oNFCStatus[6]), 1);
    check("t2_state_issue", 32'(oNFCStatus[5:4]), 1);
    check("t2_fail_before", 32'(oCommandFail), 0);
    write_cmd(32'h0000_00EE, 32'hDEAD_0000, 16'd1, 1'b0);
    @(negedge clk);
    check("t2_fail_overflow", 32'(oCommandFail), 1);
    check("t2_count_after", 32'(oNFCStatus[3:0]), 4);
    iCmdReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      repeat (3) @(posedge clk);
      pulse_done(1'b0);
    end
    @(negedge clk);
    check("t2_all_issued", 32'(sb.size()), 0);
    check("t2_last_op", 32'(oNFCStatus[23:16]), 32'h14);

    // 3: illegal opcode, then clear-fail
    write_cmd(32'h8000_0000, 32'h0, 16'h0, 1'b0);
    @(negedge clk);
    check("t3_cleared_pre", 32'(oCommandFail), 0);
    write_cmd(32'h0000_0500, 32'h4444, 16'd8, 1'b0);
    repeat (3) @(negedge clk);
    check("t3_illegal_fail", 32'(oCommandFail), 1);
    check("t3_illegal_count", 32'(oNFCStatus[3:0]), 0);
    check("t3_illegal_state", 32'(oNFCStatus[5:4]), 0);
    write_cmd(32'h8000_0000, 32'h0, 16'h0, 1'b0);
    @(negedge clk);
    check("t3_clear_fail", 32'(oCommandFail), 0);
    check("t3_clear_count", 32'(oNFCStatus[3:0]), 0);

    // 4: timeout exactly 16 cycles after accept
    write_cmd(32'h0000_0133, 32'h0000_ABCD, 16'd64, 1'b1);
    repeat (18) @(negedge clk);
    check("t4_fail_early", 32'(oCommandFail), 0);
    check("t4_state_wait", 32'(oNFCStatus[5:4]), 2);
    @(negedge clk);
    check("t4_fail_timeout", 32'(oCommandFail), 1);
    check("t4_tobit", 32'(oNFCStatus[9]), 1);
    check("t4_state_idle", 32'(oNFCStatus[5:4]), 0);
    check("t4_last_op", 32'(oNFCStatus[23:16]), 32'h33);
    pulse_done(1'b0);
    @(negedge clk);
    check("t4_late_done_state", 32'(oNFCStatus[5:4]), 0);
    check("t4_late_done_fail", 32'(oCommandFail), 1);
    write_cmd(32'h8000_0000, 32'h0, 16'h0, 1'b0);
    @(negedge clk);
    check("t4_tobit_cleared", 32'(oNFCStatus[9]), 0);

    // 5: done with error and simultaneous clear-fail: set wins
    write_cmd(32'h0000_0244, 32'h0000_5555, 16'd32, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("t5_in_wait", 32'(oNFCStatus[5:4]), 2);
    @(posedge clk); #1;
    iCmdDone = 1'b1; iCmdError = 1'b1;
    iCommand = 32'h8000_0000; iCommandValid = 1'b1;
    @(posedge clk); #1;
    iCmdDone = 1'b0; iCmdError = 1'b0; iCommandValid = 1'b0; iCommand = '0;
    @(negedge clk);
    check("t5_fail_set_wins", 32'(oCommandFail), 1);
    check("t5_last_op", 32'(oNFCStatus[23:16]), 32'h44);
    write_cmd(32'h8000_0000, 32'h0, 16'h0, 1'b0);

    // 6: reset in WAIT with two queued
    write_cmd(32'h0000_0155, 32'h0000_7000, 16'd16, 1'b1);
    repeat (3) @(posedge clk);
    write_cmd(32'h0000_0166, 32'h0000_7100, 16'd16, 1'b0);
    write_cmd(32'h0000_0177, 32'h0000_7200, 16'd16, 1'b0);
    @(negedge clk);
    check("t6_count_pre", 32'(oNFCStatus[3:0]), 2);
    check("t6_state_pre", 32'(oNFCStatus[5:4]), 2);
    check("t6_opcode_pre", 32'(oCmdOpcode), 32'h55);
    #2 rst = 1'b1;
    #1;
    check("t6_async_status", 32'(oNFCStatus), 32'h000080);
    check("t6_async_opcode", 32'(oCmdOpcode), 0);
    check("t6_async_valid", 32'(oCmdValid), 0);
    check("t6_async_fail", 32'(oCommandFail), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_post_status", 32'(oNFCStatus), 32'h000080);
    check("t6_post_valid", 32'(oCmdValid), 0);
    check("t6_sb_empty", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end
endmodule
